// File: rtl/user_proj_counter_bank_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : user_proj_counter_bank_if                              |
// | Purpose  : Wishbone slave bus bundle for the counter bank          |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
interface user_proj_counter_bank_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/user_proj_counter_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : user_proj_counter_bank                                 |
// | Purpose  : CHANNELS independent counters with compare, reload,    |
// |            sticky match and irq enable behind a Wishbone slave    |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module user_proj_counter_bank #(
  parameter int          CHANNELS  = 4,
  parameter int          WIDTH     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          IO_BITS   = 16
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  user_proj_counter_bank_if.slave  wbs,
  input  logic [127:0]             la_data_in,
  input  logic [127:0]             la_oenb,
  output logic [127:0]             la_data_out,
  input  logic [37:0]              io_in,
  output logic [37:0]              io_out,
  output logic [37:0]              io_oeb,
  output logic [2:0]               irq
);

  localparam int          LA_CH   = (CHANNELS < 4) ? CHANNELS : 4;
  localparam logic [37:0] OEB_VAL = ~((38'd1 << IO_BITS) - 38'd1);

  logic        req, hit, acc, wr, ack, block;
  logic [31:0] dat, rd, bmask;
  logic [7:0]  ch_idx;
  logic [1:0]  reg_sel;

  logic [CHANNELS*WIDTH-1:0] count_flat, cmp_flat;
  logic [CHANNELS-1:0]       en_v, reload_v, irq_en_v, match_v;

  assign ch_idx  = wbs.wbs_adr_i[11:4];
  assign reg_sel = wbs.wbs_adr_i[3:2];
  assign hit     = (wbs.wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign req     = wbs.wbs_cyc_i & wbs.wbs_stb_i;
  // An access is accepted only in a non-ack cycle and never on a strobe that
  // was already pending when reset released.
  assign acc     = req & hit & ~ack & ~block;
  assign wr      = acc & wbs.wbs_we_i;
  assign bmask   = {{8{wbs.wbs_sel_i[3]}}, {8{wbs.wbs_sel_i[2]}},
                    {8{wbs.wbs_sel_i[1]}}, {8{wbs.wbs_sel_i[0]}}};

  assign wbs.wbs_ack_o = ack;
  assign wbs.wbs_dat_o = dat;

  // Handshake state: one-cycle ack, registered read data, post-reset strobe gate
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      ack   <= 1'b0;
      dat   <= '0;
      block <= 1'b1;
    end else begin
      ack <= acc;
      dat <= acc ? rd : 32'd0;
      if (!req) block <= 1'b0;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [WIDTH-1:0] count, cmp;
    logic [31:0]      m_count, m_cmp;
    logic             en, reload, irq_en, match;
    logic             sel_ch, la_clr, at_cmp;
    logic             wr_cnt, wr_cmp, wr_ctl, w1c;

    assign sel_ch  = wr & (ch_idx == 8'(k));
    assign wr_cnt  = sel_ch & (reg_sel == 2'd0);
    assign wr_cmp  = sel_ch & (reg_sel == 2'd1);
    assign wr_ctl  = sel_ch & (reg_sel == 2'd2) & wbs.wbs_sel_i[0];
    assign w1c     = sel_ch & (reg_sel == 2'd3) & wbs.wbs_sel_i[0] & wbs.wbs_dat_i[0];
    assign la_clr  = ~la_oenb[k] & la_data_in[k];
    assign at_cmp  = en & (count == cmp);
    assign m_count = (wbs.wbs_dat_i & bmask) | (32'(count) & ~bmask);
    assign m_cmp   = (wbs.wbs_dat_i & bmask) | (32'(cmp) & ~bmask);

    // Channel state: count priority is LA clear, bus write, reload, increment
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
        count  <= '0;
        cmp    <= '0;
        en     <= 1'b0;
        reload <= 1'b0;
        irq_en <= 1'b0;
        match  <= 1'b0;
      end else begin
        if (la_clr)               count <= '0;
        else if (wr_cnt)          count <= m_count[WIDTH-1:0];
        else if (at_cmp & reload) count <= '0;
        else if (en)              count <= count + WIDTH'(1);

        if (wr_cmp) cmp <= m_cmp[WIDTH-1:0];

        if (wr_ctl) begin
          en     <= wbs.wbs_dat_i[0];
          reload <= wbs.wbs_dat_i[1];
          irq_en <= wbs.wbs_dat_i[2];
        end

        // A fresh match outranks a simultaneous write-1-to-clear.
        if (at_cmp)   match <= 1'b1;
        else if (w1c) match <= 1'b0;
      end
    end

    assign count_flat[k*WIDTH +: WIDTH] = count;
    assign cmp_flat[k*WIDTH +: WIDTH]   = cmp;
    assign en_v[k]     = en;
    assign reload_v[k] = reload;
    assign irq_en_v[k] = irq_en;
    assign match_v[k]  = match;
  end

  // Read mux; unmapped offsets in the window read as zero
  always_comb begin
    rd = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (ch_idx == 8'(k)) begin
        case (reg_sel)
          2'd0:    rd = 32'(count_flat[k*WIDTH +: WIDTH]);
          2'd1:    rd = 32'(cmp_flat[k*WIDTH +: WIDTH]);
          2'd2:    rd = {29'd0, irq_en_v[k], reload_v[k], en_v[k]};
          default: rd = {31'd0, match_v[k]};
        endcase
      end
    end
  end

  // Logic-analyzer readback of the first four channel counts
  always_comb begin
    la_data_out = '0;
    for (int k = 0; k < LA_CH; k++)
      la_data_out[32*k +: 32] = 32'(count_flat[k*WIDTH +: WIDTH]);
  end

  // Interrupt lines: channel k folds onto line k mod 3
  always_comb begin
    irq = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (match_v[k] & irq_en_v[k]) irq[k % 3] = 1'b1;
  end

  assign io_out = 38'(count_flat[IO_BITS-1:0]);
  assign io_oeb = OEB_VAL;

  logic unused_bits;
  assign unused_bits = &{1'b0, io_in, la_data_in[127:CHANNELS],
                         la_oenb[127:CHANNELS], wbs.wbs_adr_i[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_user_proj_counter_bank.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_user_proj_counter_bank                              |
// | Purpose  : self-checking bench for user_proj_counter_bank         |
// | Revision : 1.0  initial release                                   |
// +------------------------------------------------------------------+
module tb_user_proj_counter_bank;

  localparam logic [31:0] B = 32'h3000_0000;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] la_data_in, la_oenb, la_data_out;
  logic [37:0]  io_in, io_out, io_oeb;
  logic [2:0]   irq;
  int           total = 0;
  int           bad = 0;
  logic [31:0]  exp_q[$];

  user_proj_counter_bank_if wb();

  user_proj_counter_bank dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst_n),
    .wbs        (wb),
    .la_data_in (la_data_in),
    .la_oenb    (la_oenb),
    .la_data_out(la_data_out),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  // Present one access and wait up to 8 edges for ack; called at posedge+1.
  task automatic bus(input logic [31:0] a, input logic we, input logic [3:0] s,
                     input logic [31:0] d, output logic ok, output logic [31:0] rdata,
                     output int lat);
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
    wb.wbs_sel_i = s; wb.wbs_adr_i = a; wb.wbs_dat_i = d;
    ok = 1'b0; rdata = '0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) begin
        ok = 1'b1; rdata = wb.wbs_dat_o; lat = i;
        break;
      end
    end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    logic ok; logic [31:0] r; int n;
    bus(a, 1'b1, s, d, ok, r, n);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    logic ok; logic [31:0] r, e; int n;
    #12;
    total++; if (wb.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", wb.wbs_ack_o); end
    total++; if (wb.wbs_dat_o !== 32'd0) begin bad++; $display("FAIL rst_dat got=%h want=0", wb.wbs_dat_o); end
    total++; if (irq !== 3'd0) begin bad++; $display("FAIL rst_irq got=%b want=000", irq); end
    total++; if (la_data_out !== 128'd0) begin bad++; $display("FAIL rst_la got=%h want=0", la_data_out); end
    total++; if (io_out !== 38'd0) begin bad++; $display("FAIL rst_io_out got=%h want=0", io_out); end
    total++; if (io_oeb !== 38'h3F_FFFF_0000) begin bad++; $display("FAIL rst_io_oeb got=%h want=3fffff0000", io_oeb); end
    #4 rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(32'd0);
      bus(B + 32'(4 * i), 1'b0, 4'hF, 32'd0, ok, r, n);
      e = exp_q.pop_front();
      total++; if (!ok || n != 1) begin bad++; $display("FAIL rst_read_lat adr=%h got=%0d want=1", 4 * i, n); end
      total++; if (r !== e) begin bad++; $display("FAIL rst_read_dat adr=%h got=%h want=%h", 4 * i, r, e); end
      idle(1);
    end
  endtask

  task automatic test_reload();
    logic ok; logic [31:0] r, e; int n;
    wr(B + 32'h14, 4'hF, 32'd5);
    idle(1);
    wr(B + 32'h18, 4'hF, 32'd7);
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      total++; if (la_data_out[63:32] !== 32'(i % 6)) begin bad++; $display("FAIL reload_cnt step=%0d got=%h want=%h", i, la_data_out[63:32], i % 6); end
      total++; if (irq !== ((i >= 6) ? 3'b010 : 3'b000)) begin bad++; $display("FAIL reload_irq step=%0d got=%b", i, irq); end
    end
    wr(B + 32'h1C, 4'h1, 32'd1);
    total++; if (irq !== 3'b000) begin bad++; $display("FAIL w1c_clear got=%b want=000", irq); end
    for (int j = 1; j <= 5; j++) begin
      @(posedge clk); #1;
      total++; if (irq !== ((j >= 5) ? 3'b010 : 3'b000)) begin bad++; $display("FAIL w1c_rematch step=%0d got=%b", j, irq); end
    end
    idle(1);
    exp_q.push_back(32'd1);
    bus(B + 32'h1C, 1'b0, 4'hF, 32'd0, ok, r, n);
    e = exp_q.pop_front();
    total++; if (!ok || r !== e) begin bad++; $display("FAIL ch1_status got=%h ack=%b want=%h", r, ok, e); end
    idle(1);
    wr(B + 32'h18, 4'hF, 32'd0);
  endtask

  task automatic test_wrap();
    logic ok; logic [31:0] r, e, c; int n;
    idle(1); wr(B + 32'h00, 4'hF, 32'hFFFF_FFFE);
    idle(1); wr(B + 32'h04, 4'hF, 32'h10);
    idle(1); wr(B + 32'h08, 4'hF, 32'd1);
    total++; if (la_data_out[31:0] !== 32'hFFFF_FFFE) begin bad++; $display("FAIL wrap_start got=%h want=fffffffe", la_data_out[31:0]); end
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      c = 32'hFFFF_FFFE + 32'(i);
      total++; if (la_data_out[31:0] !== c) begin bad++; $display("FAIL wrap_cnt step=%0d got=%h want=%h", i, la_data_out[31:0], c); end
      total++; if (io_out !== {22'd0, c[15:0]}) begin bad++; $display("FAIL wrap_io step=%0d got=%h want=%h", i, io_out, c[15:0]); end
    end
    idle(1);
    exp_q.push_back(32'd1);
    bus(B + 32'h08, 1'b0, 4'hF, 32'd0, ok, r, n);
    e = exp_q.pop_front();
    total++; if (!ok || r !== e) begin bad++; $display("FAIL ch0_ctrl got=%h want=%h", r, e); end
    idle(1);
    exp_q.push_back(32'd0);
    bus(B + 32'h0C, 1'b0, 4'hF, 32'd0, ok, r, n);
    e = exp_q.pop_front();
    total++; if (!ok || r !== e) begin bad++; $display("FAIL ch0_status got=%h want=%h", r, e); end
    idle(1);
    wr(B + 32'h08, 4'hF, 32'd0);
  endtask

  task automatic test_la_priority();
    logic ok; logic [31:0] r, e; int n;
    idle(1); wr(B + 32'h28, 4'hF, 32'd1);
    idle(3);
    la_oenb[2] = 1'b0; la_data_in[2] = 1'b1;
    wr(B + 32'h20, 4'h1, 32'h1234);
    la_oenb[2] = 1'b1; la_data_in[2] = 1'b0;
    total++; if (la_data_out[95:64] !== 32'd0) begin bad++; $display("FAIL la_clear got=%h want=0", la_data_out[95:64]); end
    @(posedge clk); #1;
    total++; if (la_data_out[95:64] !== 32'd1) begin bad++; $display("FAIL la_resume got=%h want=1", la_data_out[95:64]); end
    idle(1); wr(B + 32'h28, 4'hF, 32'd0);
    idle(1); wr(B + 32'h20, 4'hF, 32'hAABB_CCDD);
    idle(1); wr(B + 32'h20, 4'h1, 32'h1234);
    idle(1);
    exp_q.push_back(32'hAABB_CC34);
    bus(B + 32'h20, 1'b0, 4'hF, 32'd0, ok, r, n);
    e = exp_q.pop_front();
    total++; if (!ok || r !== e) begin bad++; $display("FAIL sel_merge_cnt got=%h want=%h", r, e); end
    idle(1); wr(B + 32'h24, 4'b1010, 32'h1122_3344);
    idle(1);
    exp_q.push_back(32'h1100_3300);
    bus(B + 32'h24, 1'b0, 4'hF, 32'd0, ok, r, n);
    e = exp_q.pop_front();
    total++; if (!ok || r !== e) begin bad++; $display("FAIL sel_merge_cmp got=%h want=%h", r, e); end
  endtask

  task automatic test_window();
    logic ok; logic [31:0] r, e; int n;
    idle(1); wr(B + 32'h00, 4'hF, 32'h77);
    idle(1);
    bus(B + 32'h1000, 1'b1, 4'hF, 32'h55, ok, r, n);
    total++; if (ok !== 1'b0) begin bad++; $display("FAIL out_of_window_ack got=%b want=0", ok); end
    idle(1);
    exp_q.push_back(32'h77);
    bus(B, 1'b0, 4'hF, 32'd0, ok, r, n);
    e = exp_q.pop_front();
    total++; if (!ok || r !== e) begin bad++; $display("FAIL no_side_effect got=%h want=%h", r, e); end
    idle(1);
    exp_q.push_back(32'd0);
    bus(B + 32'h800, 1'b0, 4'hF, 32'd0, ok, r, n);
    e = exp_q.pop_front();
    total++; if (!ok || r !== e) begin bad++; $display("FAIL unmapped_800 got=%h ack=%b want=%h", r, ok, e); end
    idle(1);
    exp_q.push_back(32'd0);
    bus(B + 32'h40, 1'b0, 4'hF, 32'd0, ok, r, n);
    e = exp_q.pop_front();
    total++; if (!ok || r !== e) begin bad++; $display("FAIL unmapped_ch4 got=%h ack=%b want=%h", r, ok, e); end
  endtask

  task automatic test_reset_mid();
    logic ok, seen; logic [31:0] r, e; int n;
    idle(1); wr(B + 32'h34, 4'hF, 32'd3);
    idle(1); wr(B + 32'h38, 4'hF, 32'd7);
    idle(6);
    total++; if (irq !== 3'b001) begin bad++; $display("FAIL ch3_irq got=%b want=001", irq); end
    wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'hF; wb.wbs_adr_i = B + 32'h30;
    #2 rst_n = 1'b0;
    #1;
    total++; if (wb.wbs_ack_o !== 1'b0 || wb.wbs_dat_o !== 32'd0) begin bad++; $display("FAIL mid_rst_bus got ack=%b dat=%h want 0", wb.wbs_ack_o, wb.wbs_dat_o); end
    total++; if (irq !== 3'd0) begin bad++; $display("FAIL mid_rst_irq got=%b want=000", irq); end
    total++; if (la_data_out !== 128'd0 || io_out !== 38'd0) begin bad++; $display("FAIL mid_rst_outs got la=%h io=%h want 0", la_data_out, io_out); end
    total++; if (io_oeb !== 38'h3F_FFFF_0000) begin bad++; $display("FAIL mid_rst_oeb got=%h", io_oeb); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb.wbs_ack_o) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL held_stb_ack got=%b want=0", seen); end
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
    idle(1);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'd0);
      bus(B + 32'h30 + 32'(4 * i), 1'b0, 4'hF, 32'd0, ok, r, n);
      e = exp_q.pop_front();
      total++; if (!ok || n != 1 || r !== e) begin bad++; $display("FAIL post_rst_read reg=%0d got=%h lat=%0d want=%h", i, r, n, e); end
      idle(1);
    end
  endtask

  initial begin
    wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
    wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
    la_data_in = '0; la_oenb = '1; io_in = '0;
    test_reset();
    test_reload();
    test_wrap();
    test_la_priority();
    test_window();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
